// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
// Address and instruction widths are fixed here so that the queue entry
// struct, the bus interface and the datapath all agree on one layout.
package fetch_buffer_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Fetch control states: one outstanding memory read at most.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fb_state_t;

    // One queued fetch: address, instruction word, misalignment flag.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic              err;
    } fetch_entry_t;

    // Filler word for entries that carry no fetched data (reset, misaligned).
    localparam logic [DATA_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_buffer_if.sv
// Bus bundle of the fetch buffer: PC handshake, flush, instruction-memory
// request/response, and the decode-side head-of-queue handshake.
// slave  = the fetch buffer's view, master = the surrounding pipeline/memory.
interface fetch_buffer_if;
    import fetch_buffer_pkg::*;

    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_instr;
    logic              if_err;

    modport slave (
        input  pc_addr, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr, if_err
    );

    modport master (
        output pc_addr, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr, if_err
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small register FIFO of fetch entries. The head entry is presented
// combinationally so a pushed entry is visible the cycle after the push.
// clear drops everything and wins over a simultaneous push or pop.
module fetch_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head_entry,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             full, push_en, pop_en;
    fetch_entry_t     entries [DEPTH];

    // DEPTH is a power of two and count never exceeds it, so the MSB alone means full.
    assign empty   = (count_reg == '0);
    assign full    = count_reg[PTR_W];
    assign pop_en  = pop && !empty && !clear;
    assign push_en = push && !clear && (!full || pop_en);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;

            // Storage slot gi: written only when the write pointer selects it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_reg <= '{pc: '0, instr: NOP_INSTR, err: 1'b0};
                end else if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_entry;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign head_entry = entries[rd_ptr_reg];
    assign count      = count_reg;

    // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count_reg;
        if (push_en && !pop_en) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop_en && !push_en) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Pointers wrap naturally at DEPTH; clear resets them and the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: accepts PC addresses, issues one memory read at
// a time and queues {pc, instr} pairs for decode. A queue slot is reserved
// when an address is accepted, so a returning response always has room.
// flush drops the queue and any in-flight response (DRAIN swallows a
// response whose request was already granted).
// Optional build macro FETCH_BUFFER_ALIGN_CHK_EN: misaligned addresses are
// not fetched; an error entry {pc, NOP_INSTR, err=1} is queued instead.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fb_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              accept, misaligned, push, pc_ready_c, imem_req_c, empty;
    fetch_entry_t      push_entry, head_entry;
    logic [CNT_W-1:0]  count;

`ifdef FETCH_BUFFER_ALIGN_CHK_EN
    assign misaligned = (bus.pc_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Next-state, handshake and push decisions for the single outstanding fetch.
    always_comb begin
        state_next = state_reg;
        pc_ready_c = 1'b0;
        imem_req_c = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        push_entry = '{pc: addr_reg, instr: bus.imem_rdata, err: 1'b0};
        unique case (state_reg)
            IDLE: begin
                pc_ready_c = !bus.flush && (count < CNT_W'(DEPTH));
                accept     = bus.pc_valid && pc_ready_c;
                if (accept) begin
                    if (misaligned) begin
                        push       = 1'b1;
                        push_entry = '{pc: bus.pc_addr, instr: NOP_INSTR, err: 1'b1};
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                imem_req_c = 1'b1;
                if (bus.imem_gnt) begin
                    state_next = bus.flush ? DRAIN : WAIT;
                end else if (bus.flush) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    push       = !bus.flush;
                    state_next = IDLE;
                end else if (bus.flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any outstanding fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Address latch: holds the accepted PC for the request and the queued entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg <= '0;
        end else if (accept) begin
            addr_reg <= bus.pc_addr;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (bus.flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (bus.if_ready),
        .head_entry (head_entry),
        .count      (count),
        .empty      (empty)
    );

    // pc_ready is combinational from IDLE, so it is forced low while reset is held.
    assign bus.pc_ready  = pc_ready_c && !reset;
    assign bus.imem_req  = imem_req_c;
    assign bus.imem_addr = addr_reg;
    assign bus.if_valid  = !empty;
    assign bus.if_pc     = head_entry.pc;
    assign bus.if_instr  = head_entry.instr;
    // Without the alignment check every stored err bit is written 0.
    assign bus.if_err    = head_entry.err;

endmodule
